rtc_timer_bank: RTL
===================

# rtc_timer_bank

Parametrised multi-channel timer unit for the RTC subsystem: a calibrated prescaler derives a seconds tick from `clk_i`, and `NUM_CH` independent channels count that tick toward a per-channel target in one-shot or periodic mode. It is the next-generation replacement for the single fixed-width timer in the RTC clock path. It provides per-channel pending/overrun status with acknowledge, and a merged event pulse and interrupt level for the event unit.

## Interface
Parameters:
- `NUM_CH`, 4: number of timer channels (1..16).
- `TIMER_W`, 17: channel counter/target width.
- `PRESC_W`, 16: prescaler width.
- `PRESC_RESET`, 16'h7FFF: prescaler reload value after reset (32.768 kHz clock gives a 1 Hz tick).

Ports:
- `clk_i` in 1: the only clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `calibre_update_i` in 1: load `calibre_cnt_i` into the prescaler reload.
- `calibre_cnt_i` in PRESC_W: new reload value.
- `calibre_cnt_o` out PRESC_W: current reload value.
- `tick_o` out 1: prescaler tick strobe.
- `cfg_update_i` in 1: write the configuration of channel `cfg_ch_i`.
- `cfg_ch_i` in $clog2(NUM_CH) (min 1): target channel index. Indices ≥ NUM_CH are ignored.
- `cfg_enable_i` in 1: channel runs after the write.
- `cfg_mode_i` in 1: 0 = one-shot, 1 = periodic.
- `cfg_target_i` in TIMER_W: tick count to fire.
- `value_o` out NUM_CH*TIMER_W: packed channel counters; channel k is at `[k*TIMER_W +: TIMER_W]`.
- `ack_i` in NUM_CH: clear pending and overrun, per channel.
- `pending_o` out NUM_CH: sticky fire flags.
- `overrun_o` out NUM_CH: sticky flag, set when a channel fires while its pending bit is already set.
- `event_o` out 1: one-cycle pulse after any channel fires.
- `irq_o` out 1: `|pending_o`.

## Operation
- **Prescaler**
  - `presc_cnt` counts 0..reload.
  - `tick_o = (presc_cnt == reload) && !calibre_update_i`. On a tick, `presc_cnt` returns to 0.
  - `calibre_update_i` loads the reload value and clears `presc_cnt`. No tick is issued that cycle.
  - Reload 0 produces a tick every cycle.
- **Channel FSM states**
  - IDLE: counter holds.
  - RUN: counter increments on each tick.
- **Configuration write** (`cfg_update_i`): clears the counter, latches target and mode, and enters RUN if `cfg_enable_i`, otherwise IDLE. Pending and overrun are not touched.
- **Fire condition**: in RUN, on a tick where `count + 1 >= max(target, 1)`. Target 0 behaves as 1.
  - Periodic: count becomes 0 and the channel stays in RUN.
  - One-shot: count becomes `max(target,1)` and the channel goes to IDLE.
- **Flags on fire**
  - `pending[k]` is set.
  - If `pending[k]` was already 1 and `ack_i[k]` is 0, `overrun[k]` is also set.
- **Priority rules**
  - A config write to channel k beats a tick in the same cycle; that tick is lost for channel k only.
  - Fire beats ack in the same cycle: pending stays 1. Overrun is not set, because the ack retired the old pending.
  - Ack with no fire clears both pending and overrun.
- **Arithmetic**: counters are unsigned TIMER_W. The fire check prevents wrap for targets below 2^TIMER_W.

## Timing
- All outputs except `tick_o` and `irq_o` are registered.
- **Reset values**:
  - counters 0, targets 0, modes one-shot, all channels IDLE;
  - pending 0, overrun 0, `event_o` 0;
  - reload = PRESC_RESET, `presc_cnt` 0, so `tick_o` 0.
- A tick in cycle T updates counters and `pending_o`, visible in T+1. `event_o` is high in T+1 only, and pulses on every fire even if the bit was already pending.
- A config write in cycle T is visible on `value_o` (0) in T+1. The first possible increment is on a tick in T+1.
- An ack in T clears the flags in T+1.
- Asynchronous reset mid-count returns every register to its reset value immediately. No tick is generated on release.

## Structure
- Package `rtc_timer_pkg`:
  - `mode_e` (ONESHOT, PERIODIC) and `ch_state_e` (IDLE, RUN) typedefs;
  - `PRESC_RESET_DEFAULT` constant.
- Sub-module `rtc_timer_ch`: one channel (FSM, counter, target, pending, overrun, fire strobe), instantiated NUM_CH times with a generate loop.
- The top level holds the prescaler, the config-index decode, and the event/irq merge.

## Test plan
- Reset, then observe the free-running prescaler → with default reload, `tick_o` first pulses at cycle 32768 after reset and then every 32768 cycles; all outputs stay at their reset values until then.
- Calibrate to 3, configure ch0 periodic target 2 → ch0 fires on every 2nd tick (every 8 cycles); `event_o` pulses one cycle after each fire; `value_o[ch0]` sequence is 0,1,0,1.
- Ch1 one-shot target 5 → fires once on the 5th tick, `value_o` holds 5, the channel goes IDLE, and no further events follow.
- Ch2 periodic target 1 with no ack → second fire sets `overrun_o[2]`; ack in the same cycle as a third fire leaves pending=1 and overrun=0.
- `cfg_update_i` to ch3 in the same cycle as `tick_o` → ch3 counter reads 0 next cycle; the other channels increment normally.
- Assert `rstn_i` low for one cycle mid-run → all flags, counters and the reload return to their reset values; `event_o` stays 0.

Source files
------------

// File: rtl/rtc_timer_pkg.sv
// Shared types and constants for the RTC timer bank.
package rtc_timer_pkg;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // A 32.768 kHz clock divided by 0x7FFF + 1 gives a 1 Hz tick.
  localparam logic [15:0] PRESC_RESET_DEFAULT = 16'h7FFF;

endpackage : rtc_timer_pkg

// File: rtl/rtc_timer_ch.sv
// One timer channel: run/idle FSM, tick counter, target, sticky flags and a fire strobe.
module rtc_timer_ch
  import rtc_timer_pkg::*;
#(
  parameter int TIMER_W = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               cfg_write,
  input  logic               cfg_enable,
  input  mode_e              cfg_mode,
  input  logic [TIMER_W-1:0] cfg_target,
  input  logic               ack,
  output logic [TIMER_W-1:0] value,
  output logic               pending,
  output logic               overrun,
  output logic               fire
);

  ch_state_e          state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic [TIMER_W-1:0] target_q, target_d;
  logic [TIMER_W-1:0] eff_target;
  logic               reached;

  // A zero target behaves like one; the compare is one bit wider so count + 1 cannot wrap.
  assign eff_target = (target_q == '0) ? TIMER_W'(1) : target_q;
  assign reached    = ({1'b0, count_q} + (TIMER_W + 1)'(1)) >= {1'b0, eff_target};

  // Next-state logic: a config write wins over any tick arriving in the same cycle.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    target_d = target_q;
    fire     = 1'b0;
    if (cfg_write) begin
      count_d  = '0;
      target_d = cfg_target;
      mode_d   = cfg_mode;
      state_d  = cfg_enable ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            if (reached) begin
              fire = 1'b1;
              if (mode_q == PERIODIC) begin
                count_d = '0;
              end else begin
                count_d = eff_target;
                state_d = IDLE;
              end
            end else begin
              count_d = count_q + TIMER_W'(1);
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State, counter and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= ONESHOT;
      count_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      target_q <= target_d;
    end
  end

  // Sticky flags: a fire beats an ack, and an ack in the fire cycle retires the old pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (fire) begin
        pending <= 1'b1;
      end else if (ack) begin
        pending <= 1'b0;
      end
      if (fire && pending && !ack) begin
        overrun <= 1'b1;
      end else if (ack) begin
        overrun <= 1'b0;
      end
    end
  end

  assign value = count_q;

endmodule : rtc_timer_ch

// File: rtl/rtc_timer_bank.sv
// Multi-channel RTC timer: calibrated prescaler, per-channel timers and merged event/irq.
module rtc_timer_bank
  import rtc_timer_pkg::*;
#(
  parameter int              NUM_CH      = 4,
  parameter int              TIMER_W     = 17,
  parameter int              PRESC_W     = 16,
  parameter logic [PRESC_W-1:0] PRESC_RESET = PRESC_W'(PRESC_RESET_DEFAULT),
  localparam int             CH_IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      calibre_update_i,
  input  logic [PRESC_W-1:0]        calibre_cnt_i,
  output logic [PRESC_W-1:0]        calibre_cnt_o,
  output logic                      tick_o,
  input  logic                      cfg_update_i,
  input  logic [CH_IDX_W-1:0]       cfg_ch_i,
  input  logic                      cfg_enable_i,
  input  logic                      cfg_mode_i,
  input  logic [TIMER_W-1:0]        cfg_target_i,
  output logic [NUM_CH*TIMER_W-1:0] value_o,
  input  logic [NUM_CH-1:0]         ack_i,
  output logic [NUM_CH-1:0]         pending_o,
  output logic [NUM_CH-1:0]         overrun_o,
  output logic                      event_o,
  output logic                      irq_o
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] reload_q;
  logic [NUM_CH-1:0]  cfg_sel;
  logic [NUM_CH-1:0]  fire_vec;
  logic               event_q;

  // A calibration write suppresses the tick so the new period starts cleanly.
  assign tick_o = (presc_q == reload_q) && !calibre_update_i;

  // Prescaler counts 0..reload and restarts on a tick or a calibration write.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q  <= '0;
      reload_q <= PRESC_RESET;
    end else if (calibre_update_i) begin
      presc_q  <= '0;
      reload_q <= calibre_cnt_i;
    end else if (tick_o) begin
      presc_q  <= '0;
    end else begin
      presc_q  <= presc_q + PRESC_W'(1);
    end
  end

  assign calibre_cnt_o = reload_q;

  // Channel array; out-of-range indices never match any channel and are dropped.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign cfg_sel[k] = cfg_update_i && (cfg_ch_i == CH_IDX_W'(k));

    rtc_timer_ch #(
      .TIMER_W (TIMER_W)
    ) u_ch (
      .clk        (clk_i),
      .rst_n      (rstn_i),
      .tick       (tick_o),
      .cfg_write  (cfg_sel[k]),
      .cfg_enable (cfg_enable_i),
      .cfg_mode   (mode_e'(cfg_mode_i)),
      .cfg_target (cfg_target_i),
      .ack        (ack_i[k]),
      .value      (value_o[k*TIMER_W +: TIMER_W]),
      .pending    (pending_o[k]),
      .overrun    (overrun_o[k]),
      .fire       (fire_vec[k])
    );
  end

  // One-cycle event pulse for every fire, regardless of earlier pending state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      event_q <= 1'b0;
    end else begin
      event_q <= |fire_vec;
    end
  end

  assign event_o = event_q;
  assign irq_o   = |pending_o;

endmodule : rtc_timer_bank
